// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave transmit path.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_tx_state_t;

    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_tx_fifo.sv
// Small synchronous FIFO holding bytes queued for MISO; flags and count are registered.
module spi_tx_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [SPI_BYTE_W-1:0]         push_data,
    input  logic                          pop,
    output logic [SPI_BYTE_W-1:0]         head,
    output logic                          ready,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [SPI_BYTE_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nx_s;
    logic                  ready_r;
    logic                  empty_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Accept only against registered flags: a full FIFO never takes a byte, even alongside a pop.
    always_comb begin
        push_ok_s = push & ready_r;
        pop_ok_s  = pop & ~empty_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b1;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nx_s;
            ready_r <= (count_nx_s != CNT_FULL);
            empty_r <= (count_nx_s == {CW{1'b0}});
        end
    end

    // Storage array; contents are discarded logically by the pointer reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign head  = mem_r[rd_ptr_r];
    assign ready = ready_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmit path: serialises queued bytes LSB-first on MISO, one byte per SS frame.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int unsigned               DEPTH     = 4,
    parameter logic [SPI_BYTE_W-1:0]     IDLE_BYTE = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SCK,
    input  logic                          SS,
    output logic                          MISO,
    output logic                          miso_oe,
    input  logic [SPI_BYTE_W-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          byte_sent,
    output logic                          underrun,
    output logic                          aborted,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count
);

    logic [SPI_SYNC_STAGES-1:0] sck_sync_r;
    logic [SPI_SYNC_STAGES-1:0] ss_sync_r;
    logic [SPI_SYNC_STAGES-1:0] vld_sync_r;
    logic                       sck_prev_r;
    logic                       ss_prev_r;
    logic                       armed_r;
    logic                       sck_s, ss_s;
    logic                       sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;

    spi_tx_state_t              state_r, state_nx_s;
    logic [SPI_BYTE_W-1:0]      shreg_r, shreg_nx_s, fifo_head_s;
    logic [3:0]                 cnt_r, cnt_nx_s, cnt_inc_s;
    logic                       src_r, src_nx_s;
    logic                       pop_s, fifo_empty_s;
    logic                       sent_nx_s, under_nx_s, abort_nx_s, miso_nx_s;
    logic                       miso_r, miso_oe_r, sent_r, under_r, abort_r;

    assign sck_s      = sck_sync_r[SPI_SYNC_STAGES-1];
    assign ss_s       = ss_sync_r[SPI_SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign ss_rise_s  = ss_s & ~ss_prev_r;
    assign ss_fall_s  = ~ss_s & ss_prev_r;

    // Pin synchronisers and edge-detect flops; armed_r blocks a frame until SS is really seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_r <= {SPI_SYNC_STAGES{1'b0}};
            ss_sync_r  <= {SPI_SYNC_STAGES{1'b1}};
            vld_sync_r <= {SPI_SYNC_STAGES{1'b0}};
            sck_prev_r <= 1'b0;
            ss_prev_r  <= 1'b1;
            armed_r    <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SPI_SYNC_STAGES-2:0], SCK};
            ss_sync_r  <= {ss_sync_r[SPI_SYNC_STAGES-2:0], SS};
            vld_sync_r <= {vld_sync_r[SPI_SYNC_STAGES-2:0], 1'b1};
            sck_prev_r <= sck_s;
            ss_prev_r  <= ss_s;
            armed_r    <= armed_r | (vld_sync_r[SPI_SYNC_STAGES-1] & ss_s);
        end
    end

    // Frame FSM next-state, shift control and pulse generation.
    always_comb begin
        state_nx_s = state_r;
        shreg_nx_s = shreg_r;
        cnt_nx_s   = cnt_r;
        src_nx_s   = src_r;
        pop_s      = 1'b0;
        sent_nx_s  = 1'b0;
        under_nx_s = 1'b0;
        abort_nx_s = 1'b0;
        if (sck_rise_s && (cnt_r < 4'd8)) begin
            cnt_inc_s = cnt_r + 4'd1;
        end else begin
            cnt_inc_s = cnt_r;
        end
        case (state_r)
            IDLE: begin
                if (ss_fall_s && armed_r) begin
                    state_nx_s = ACTIVE;
                    cnt_nx_s   = 4'd0;
                    if (fifo_empty_s) begin
                        shreg_nx_s = IDLE_BYTE;
                        src_nx_s   = 1'b0;
                        under_nx_s = 1'b1;
                    end else begin
                        shreg_nx_s = fifo_head_s;
                        src_nx_s   = 1'b1;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACTIVE: begin
                cnt_nx_s = cnt_inc_s;
                if (sck_fall_s && (cnt_r >= 4'd1) && (cnt_r <= 4'd7)) begin
                    shreg_nx_s = {1'b1, shreg_r[SPI_BYTE_W-1:1]};
                end else begin
                    shreg_nx_s = shreg_r;
                end
                // The eighth rise completes the byte even when SS rises in the same cycle.
                if (cnt_inc_s == 4'd8) begin
                    pop_s     = src_r;
                    sent_nx_s = src_r;
                end else begin
                    pop_s     = 1'b0;
                    sent_nx_s = 1'b0;
                end
                if (ss_rise_s) begin
                    state_nx_s = IDLE;
                    abort_nx_s = (cnt_inc_s != 4'd8);
                end else if (cnt_inc_s == 4'd8) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = ACTIVE;
                end
            end
            DONE: begin
                if (ss_rise_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        if (state_nx_s == IDLE) begin
            miso_nx_s = 1'b1;
        end else begin
            miso_nx_s = shreg_nx_s[0];
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shreg_r   <= IDLE_BYTE;
            cnt_r     <= 4'd0;
            src_r     <= 1'b0;
            miso_r    <= 1'b1;
            miso_oe_r <= 1'b0;
            sent_r    <= 1'b0;
            under_r   <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            shreg_r   <= shreg_nx_s;
            cnt_r     <= cnt_nx_s;
            src_r     <= src_nx_s;
            miso_r    <= miso_nx_s;
            miso_oe_r <= ~ss_s;
            sent_r    <= sent_nx_s;
            under_r   <= under_nx_s;
            abort_r   <= abort_nx_s;
        end
    end

    spi_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .ready     (tx_ready),
        .empty     (fifo_empty_s),
        .count     (fifo_count)
    );

    assign MISO      = miso_r;
    assign miso_oe   = miso_oe_r;
    assign byte_sent = sent_r;
    assign underrun  = under_r;
    assign aborted   = abort_r;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Scoreboard bench for spi_slave_tx: directed frames with queued expected bytes and status pulses.
module tb_spi_slave_tx;

    localparam logic [2:0] EV_SENT  = 3'b001;
    localparam logic [2:0] EV_UNDER = 3'b010;
    localparam logic [2:0] EV_ABORT = 3'b100;

    logic       clk;
    logic       rst;
    logic       SCK;
    logic       SS;
    logic       MISO;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       byte_sent;
    logic       underrun;
    logic       aborted;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_ev_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] got_rx_q[$];

    spi_slave_tx #(
        .DEPTH     (4),
        .IDLE_BYTE (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SCK        (SCK),
        .SS         (SS),
        .MISO       (MISO),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .byte_sent  (byte_sent),
        .underrun   (underrun),
        .aborted    (aborted),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] rx, input logic [2:0] ev);
        exp_rx_q.push_back(rx);
        exp_ev_q.push_back(ev);
    endtask

    // Master side: SS low, nbits SCK pulses sampling MISO on each rise, SS high.
    task automatic frame(input int nbits, input bit record, input bit push_at_pop);
        logic [7:0] rx;
        rx = 8'h00;
        SS = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            SCK   = 1'b1;
            rx[i] = MISO;
            if (push_at_pop && (i == 7)) begin
                wait_clk(2);
                tx_data  = 8'h99;
                tx_valid = 1'b1;
                wait_clk(1);
                tx_valid = 1'b0;
                check("pop_at_full_count", 32'(fifo_count), 32'd3);
                check("pop_at_full_ready", 32'(tx_ready), 32'd1);
                wait_clk(5);
            end else begin
                wait_clk(8);
            end
            SCK = 1'b0;
            wait_clk(8);
        end
        SS = 1'b1;
        wait_clk(10);
        if (record) got_rx_q.push_back(rx);
    endtask

    // Status-pulse monitor: every asserted pulse must match the next queued expectation.
    always @(posedge clk) begin
        logic [2:0] ev;
        logic [2:0] exp_ev;
        #1;
        ev = {aborted, underrun, byte_sent};
        if (ev != 3'b000) begin
            checks++;
            if (exp_ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual=%b expected=none", ev);
            end else begin
                exp_ev = exp_ev_q.pop_front();
                if (ev !== exp_ev) begin
                    errors++;
                    $display("FAIL pulse actual=%b expected=%b", ev, exp_ev);
                end
            end
        end
    end

    // Received-byte monitor: compares what the master shifted in against the expected byte.
    always @(posedge clk) begin
        logic [7:0] got;
        logic [7:0] exp_b;
        if (got_rx_q.size() != 0) begin
            got = got_rx_q.pop_front();
            checks++;
            if (exp_rx_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rx actual=%02h expected=none", got);
            end else begin
                exp_b = exp_rx_q.pop_front();
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL rx_byte actual=%02h expected=%02h", got, exp_b);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        SCK      = 1'b0;
        SS       = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        wait_clk(5);
        check("rst_miso", 32'(MISO), 32'd1);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_pulses", 32'({byte_sent, underrun, aborted}), 32'd0);
        rst = 1'b0;
        wait_clk(6);

        // Basic byte A5.
        push_byte(8'hA5);
        check("a5_count_before", 32'(fifo_count), 32'd1);
        expect_frame(8'hA5, EV_SENT);
        frame(8, 1'b1, 1'b0);
        check("a5_count_after", 32'(fifo_count), 32'd0);
        check("idle_miso", 32'(MISO), 32'd1);

        // Empty FIFO frame.
        expect_frame(8'hFF, EV_UNDER);
        frame(8, 1'b1, 1'b0);
        check("under_count", 32'(fifo_count), 32'd0);

        // Aborted frame keeps the byte for the next frame.
        push_byte(8'h3C);
        exp_ev_q.push_back(EV_ABORT);
        frame(4, 1'b0, 1'b0);
        check("abort_count", 32'(fifo_count), 32'd1);
        expect_frame(8'h3C, EV_SENT);
        frame(8, 1'b1, 1'b0);
        check("abort_retx_count", 32'(fifo_count), 32'd0);

        // Overfill: fifth push dropped.
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check("fill3_ready", 32'(tx_ready), 32'd1);
        push_byte(8'h04);
        check("fill4_ready", 32'(tx_ready), 32'd0);
        check("fill4_count", 32'(fifo_count), 32'd4);
        push_byte(8'h05);
        check("overfill_count", 32'(fifo_count), 32'd4);
        expect_frame(8'h01, EV_SENT);
        frame(8, 1'b1, 1'b0);
        expect_frame(8'h02, EV_SENT);
        frame(8, 1'b1, 1'b0);
        expect_frame(8'h03, EV_SENT);
        frame(8, 1'b1, 1'b0);
        expect_frame(8'h04, EV_SENT);
        frame(8, 1'b1, 1'b0);
        check("drain_count", 32'(fifo_count), 32'd0);

        // Push exactly on the pop cycle while full: rejected.
        push_byte(8'h10);
        push_byte(8'h11);
        push_byte(8'h12);
        push_byte(8'h13);
        expect_frame(8'h10, EV_SENT);
        frame(8, 1'b1, 1'b1);
        expect_frame(8'h11, EV_SENT);
        frame(8, 1'b1, 1'b0);
        expect_frame(8'h12, EV_SENT);
        frame(8, 1'b1, 1'b0);
        expect_frame(8'h13, EV_SENT);
        frame(8, 1'b1, 1'b0);
        expect_frame(8'hFF, EV_UNDER);
        frame(8, 1'b1, 1'b0);

        // Reset mid-frame with SS held low through release.
        push_byte(8'h20);
        push_byte(8'h21);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        SS = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 3; i++) begin
            SCK = 1'b1;
            wait_clk(8);
            SCK = 1'b0;
            wait_clk(8);
        end
        rst = 1'b1;
        wait_clk(3);
        check("midrst_miso", 32'(MISO), 32'd1);
        check("midrst_oe", 32'(miso_oe), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 8; i++) begin
            SCK = 1'b1;
            check("post_rst_miso", 32'(MISO), 32'd1);
            wait_clk(8);
            SCK = 1'b0;
            wait_clk(8);
        end
        SS = 1'b1;
        wait_clk(10);
        check("post_rst_count", 32'(fifo_count), 32'd0);
        expect_frame(8'hFF, EV_UNDER);
        frame(8, 1'b1, 1'b0);

        wait_clk(20);
        check("leftover_pulses", 32'(exp_ev_q.size()), 32'd0);
        check("leftover_bytes", 32'(exp_rx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx.md
Name: spi_slave_tx

Overview:
- SPI slave transmit path: returns recognizer results and status bytes to the external SPI master on MISO.
- Same frame format the master already uses on MOSI:
  - SS low for exactly one byte.
  - 8 SCK pulses per byte, LSB first.
  - Master samples on SCK rising edge; slave changes data on SCK falling edge.
- Sits beside the existing SPI receive path inside digit_recognizer_final.
- Core logic pushes bytes into a small FIFO; the block serialises one byte per SS frame.

Parameters:
- DEPTH, 4: FIFO entries (power of 2, ≥2).
- IDLE_BYTE, 8'hFF: byte shifted out when a frame starts with the FIFO empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- SCK  in  1  SPI clock from master, asynchronous to clk.
- SS  in  1  slave select, active-low, asynchronous.
- MISO  out  1  serial data to master.
- miso_oe  out  1  MISO output enable (high while SS is low after sync).
- tx_data  in  8  byte to enqueue.
- tx_valid  in  1  enqueue request.
- tx_ready  out  1  FIFO not full.
- byte_sent  out  1  one-clk pulse when a FIFO byte completes 8 bits.
- underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
- aborted  out  1  one-clk pulse when SS rises before 8 rising SCK edges.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Synchronisation and edge detect:
  - SCK and SS each pass through 2 flops, then 1 edge-detect flop.
  - An SCK/SS pin edge is acted on 3 clk after it occurs.
  - MISO changes ≤4 clk after an SCK fall.
  - Requirement: SCK half-period ≥ 6 clk (nominal 83 ns SPI vs 5 ns clk gives 8).
- Reset values:
  - SCK sync chain resets to 0; SS sync chain resets to 1.
  - state=IDLE, FIFO empty, shift register=IDLE_BYTE.
  - MISO=1, miso_oe=0, tx_ready=1, all pulses=0, fifo_count=0.
- FIFO (push side):
  - Push when tx_valid && tx_ready.
  - tx_ready is derived from registered count; a push while full is ignored and never overwrites.
  - Push and pop in the same cycle: both take effect, count unchanged; at full the push is still rejected (no bypass).
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE:
    - On synced SS fall, load shreg from FIFO head (no pop yet), clear rise_cnt, go to ACTIVE.
    - If the FIFO is empty, load IDLE_BYTE and pulse underrun.
    - A push landing in the same cycle as the SS fall does not count; the frame is still an underrun.
  - ACTIVE:
    - MISO = shreg[0], so bit0 is valid before the first rising edge.
    - On synced SCK rise: rise_cnt++.
    - On synced SCK fall with 1 ≤ rise_cnt ≤ 7: shift shreg right by 1.
    - Falls with rise_cnt = 0 or 8 are ignored.
    - When rise_cnt reaches 8: if the frame was FIFO-sourced, pop and pulse byte_sent; go to DONE.
    - SS rise with rise_cnt < 8: pulse aborted, no pop (byte retransmitted next frame), go to IDLE.
    - SCK rise and SS rise in the same cycle: the rise is processed first.
  - DONE:
    - Further SCK edges are ignored; MISO holds the last bit.
    - On SS rise, go to IDLE.
- miso_oe = synced SS low.
- MISO = 1 whenever state=IDLE.
- Reset mid-frame:
  - Returns to reset values; any partial byte and all FIFO contents are dropped.
  - If SS is already low at reset release, no frame starts until SS is seen high then low.
- rise_cnt is 4 bits and saturates at 8.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [1:0] {IDLE, ACTIVE, DONE} spi_tx_state_t.
  - localparam SPI_BYTE_W = 8.
  - localparam SPI_SYNC_STAGES = 2.
- Sub-module spi_tx_fifo: DEPTH-entry synchronous FIFO with push/pop/full/empty/count, same clk/rst.
- Synchroniser, edge detect and FSM stay in spi_slave_tx.

Test Plan:
- Push 8'hA5, then run one full 8-bit frame → master samples bits 1,0,1,0,0,1,0,1 (LSB first); byte_sent pulses once; fifo_count 1→0.
- Frame with FIFO empty → 8'hFF received; underrun pulses once; byte_sent stays 0.
- Push 8'h3C; SS rises after 4 SCK pulses → aborted pulses; fifo_count stays 1; next full frame returns 8'h3C.
- Push 5 bytes 8'h01..8'h05 with DEPTH=4 → tx_ready low after the 4th; 8'h05 is dropped; four frames return 01,02,03,04.
- Assert rst mid-frame after 3 bits with 2 bytes queued → MISO=1, miso_oe=0, fifo_count=0; SS held low through release starts no frame.
- Push on the exact cycle of a pop at full (DEPTH=4) → push rejected; fifo_count goes 4→3.
